// File: rtl/controle_varredura_torreta.sv
// Turret sweep-and-engage scheduler: ping-pong servo sweep, one
// ultrasonic measurement per position, fire handshake on close threats.
module controle_varredura_torreta #(
    parameter int          T_ASSENTAMENTO = 25_000_000,
    parameter int          T_TIMEOUT      = 1_500_000,
    parameter int          N_POSICOES     = 8,
    parameter logic [11:0] LIMIAR_BCD     = 12'h050
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ligar,
    input  logic        fim_medida,
    input  logic [11:0] medida,
    input  logic        municao_vazia,
    input  logic        disparo_feito,
    output logic        mede,
    output logic [2:0]  posicao,
    output logic        pede_disparo,
    output logic        ameaca_detectada,
    output logic        fim_posicao,
    output logic        erro_medida,
    output logic [3:0]  db_estado
);

    typedef enum logic [3:0] {
        INICIAL = 4'd0,
        PREPARA = 4'd1,
        ASSENTA = 4'd2,
        MEDE    = 4'd3,
        AGUARDA = 4'd4,
        AVALIA  = 4'd5,
        DISPARA = 4'd6,
        PROXIMA = 4'd7
    } estado_t;

    // One shared counter serves both the settle wait and the timeout.
    localparam int TMAX = (T_ASSENTAMENTO > T_TIMEOUT) ?
                          T_ASSENTAMENTO : T_TIMEOUT;
    localparam int CW   = $clog2(TMAX + 1);

    localparam logic [CW-1:0] FIM_ASS = CW'(T_ASSENTAMENTO - 1);
    localparam logic [CW-1:0] FIM_TO  = CW'(T_TIMEOUT - 1);
    localparam logic [CW-1:0] UM      = CW'(1);
    localparam logic [2:0]    POS_MAX = 3'(N_POSICOES - 1);

    estado_t       estado_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    pos_q;
    logic          desce_q;
    logic          ameaca_q;
    logic          pede_q;
    logic          erro_q;
    logic [11:0]   medida_q;

    logic [2:0]    pos_d;
    logic          desce_d;
    logic          ameaca_d;

    // BCD digit order matches numeric order, so a binary compare works.
    assign ameaca_d = (medida_q < LIMIAR_BCD);

    // Next sweep position: bounce off both ends of the range.
    always_comb begin
        pos_d   = pos_q;
        desce_d = desce_q;
        if (!desce_q) begin
            if (pos_q == POS_MAX) begin
                desce_d = 1'b1;
                pos_d   = POS_MAX - 3'd1;
            end else begin
                pos_d = pos_q + 3'd1;
            end
        end else begin
            if (pos_q == 3'd0) begin
                desce_d = 1'b0;
                pos_d   = 3'd1;
            end else begin
                pos_d = pos_q - 3'd1;
            end
        end
    end

    // Main scheduler; every output is a register or a state decode.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q <= INICIAL;
            cnt_q    <= '0;
            pos_q    <= '0;
            desce_q  <= 1'b0;
            ameaca_q <= 1'b0;
            pede_q   <= 1'b0;
            erro_q   <= 1'b0;
            medida_q <= '0;
        end else begin
            erro_q <= 1'b0;
            unique case (estado_q)
                INICIAL: begin
                    if (ligar)
                        estado_q <= PREPARA;
                end
                PREPARA: begin
                    pos_q    <= '0;
                    desce_q  <= 1'b0;
                    ameaca_q <= 1'b0;
                    cnt_q    <= '0;
                    estado_q <= ligar ? ASSENTA : INICIAL;
                end
                ASSENTA: begin
                    if (!ligar) begin
                        estado_q <= INICIAL;
                    end else if (cnt_q == FIM_ASS) begin
                        cnt_q    <= '0;
                        estado_q <= MEDE;
                    end else begin
                        cnt_q <= cnt_q + UM;
                    end
                end
                MEDE: begin
                    cnt_q    <= '0;
                    estado_q <= ligar ? AGUARDA : INICIAL;
                end
                AGUARDA: begin
                    if (!ligar) begin
                        estado_q <= INICIAL;
                    end else if (fim_medida) begin
                        // A result in the timeout cycle still counts.
                        medida_q <= medida;
                        estado_q <= AVALIA;
                    end else if (cnt_q == FIM_TO) begin
                        erro_q   <= 1'b1;
                        ameaca_q <= 1'b0;
                        estado_q <= PROXIMA;
                    end else begin
                        cnt_q <= cnt_q + UM;
                    end
                end
                AVALIA: begin
                    ameaca_q <= ameaca_d;
                    if (!ligar)
                        estado_q <= INICIAL;
                    else if (ameaca_d && !municao_vazia)
                        estado_q <= DISPARA;
                    else
                        estado_q <= PROXIMA;
                end
                DISPARA: begin
                    // Request rises one cycle in; the ack is only
                    // honoured once the request is visible.
                    if (!pede_q) begin
                        pede_q <= 1'b1;
                    end else if (disparo_feito) begin
                        pede_q   <= 1'b0;
                        estado_q <= ligar ? PROXIMA : INICIAL;
                    end
                end
                PROXIMA: begin
                    pos_q    <= pos_d;
                    desce_q  <= desce_d;
                    cnt_q    <= '0;
                    estado_q <= ligar ? ASSENTA : INICIAL;
                end
                default: begin
                    estado_q <= INICIAL;
                end
            endcase
        end
    end

    assign mede             = (estado_q == MEDE);
    assign fim_posicao      = (estado_q == PROXIMA);
    assign posicao          = pos_q;
    assign pede_disparo     = pede_q;
    assign ameaca_detectada = ameaca_q;
    assign erro_medida      = erro_q;
    assign db_estado        = estado_q;

endmodule
